// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: instruction field
// encodings, datapath mux select codes, the FSM state type and the bundle of
// single-bit and select control signals driven by the FSM.
package ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnDiv  = 6'b011010;
  localparam logic [5:0] FnMfhi = 6'b010000;
  localparam logic [5:0] FnMflo = 6'b010010;

  // ALU operations
  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluNor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluMult = 3'b110;
  localparam logic [2:0] AluDiv  = 3'b111;

  // Register file destination select
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  // Register file write-data select
  localparam logic [1:0] MemToRegAlu  = 2'b00;
  localparam logic [1:0] MemToRegMdr  = 2'b01;
  localparam logic [1:0] MemToRegPc   = 2'b10;
  localparam logic [1:0] MemToRegHiLo = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec,
    StAluWb, StMdWait, StAddiEx, StAddiWb, StBranch, StJump, StJal
  } state_e;

  typedef struct packed {
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       hilo_write;
    logic       hilo_sel;
    logic       md_start;
    logic       md_busy;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter that times the mult/div unit.
//   clk_i, rst_i   : clock, asynchronous active-high reset (count -> 0)
//   load_i         : load load_value_i (takes priority over enable_i)
//   load_value_i   : remaining cycles minus one
//   enable_i       : decrement while non-zero
//   done_o         : count has reached zero
module md_latency_counter #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             enable_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_value_i;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing a multi-cycle MIPS datapath (shared memory, one ALU)
// with timed mult/div, HI/LO writeback and jal link.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   opcode_i, funct_i    : IR[31:26], IR[5:0]; read only in DECODE onwards
//   zero_i               : ALU zero flag, only feeds pc_en_o
//   pc_en_o              : pc_write | (pc_write_cond & zero)
//   remaining outputs    : datapath mux selects and strobes, all 0 in reset
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 8,
  parameter int unsigned ALU_CTRL_W  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [5:0]            opcode_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  output logic                  pc_en_o,
  output logic                  ir_write_o,
  output logic                  i_or_d_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  reg_write_o,
  output logic [1:0]            reg_dst_o,
  output logic [1:0]            mem_to_reg_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic [1:0]            pc_source_o,
  output logic                  hilo_write_o,
  output logic                  hilo_sel_o,
  output logic                  md_start_o,
  output logic                  md_busy_o,
  output logic                  illegal_op_o
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  state_e          state_q, state_d;
  ctrl_t           ctrl, ctrl_out;
  logic [2:0]      alu_op;
  logic            md_load, md_done;
  logic [CntW-1:0] md_load_value;

  md_latency_counter #(
    .Width(CntW)
  ) u_md_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (md_load),
    .load_value_i(md_load_value),
    .enable_i    (state_q == StMdWait),
    .done_o      (md_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ctrl          = '0;
    alu_op        = AluAdd;
    md_load       = 1'b0;
    md_load_value = '0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.pc_write  = 1'b1;
        state_d        = StDecode;
      end
      StDecode: begin
        // Speculative branch target into ALUOut.
        ctrl.alu_src_b = SrcBImmSh;
        case (opcode_i)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpAddi:     state_d = StAddiEx;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpJal:      state_d = StJal;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        state_d        = (opcode_i == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        state_d       = StMemWb;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RegDstRt;
        ctrl.mem_to_reg = MemToRegMdr;
        state_d         = StFetch;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        state_d        = StFetch;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBReg;
        state_d        = StAluWb;
        case (funct_i)
          FnAdd: alu_op = AluAdd;
          FnSub: alu_op = AluSub;
          FnAnd: alu_op = AluAnd;
          FnOr:  alu_op = AluOr;
          FnNor: alu_op = AluNor;
          FnSlt: alu_op = AluSlt;
          FnMult: begin
            alu_op        = AluMult;
            ctrl.md_start = 1'b1;
            md_load       = 1'b1;
            md_load_value = CntW'(MULT_CYCLES - 1);
            state_d       = StMdWait;
          end
          FnDiv: begin
            alu_op        = AluDiv;
            ctrl.md_start = 1'b1;
            md_load       = 1'b1;
            md_load_value = CntW'(DIV_CYCLES - 1);
            state_d       = StMdWait;
          end
          FnMfhi, FnMflo: state_d = StAluWb;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = StFetch;
          end
        endcase
      end
      StAluWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RegDstRd;
        if ((funct_i == FnMfhi) || (funct_i == FnMflo)) begin
          ctrl.mem_to_reg = MemToRegHiLo;
          ctrl.hilo_sel   = (funct_i == FnMflo);
        end
        state_d = StFetch;
      end
      StMdWait: begin
        ctrl.md_busy = 1'b1;
        if (md_done) begin
          ctrl.hilo_write = 1'b1;
          state_d         = StFetch;
        end
      end
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        state_d        = StAddiWb;
      end
      StAddiWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RegDstRt;
        ctrl.mem_to_reg = MemToRegAlu;
        state_d         = StFetch;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SrcBReg;
        alu_op             = AluSub;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PcSrcAluOut;
        state_d            = StFetch;
      end
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PcSrcJump;
        state_d        = StFetch;
      end
      StJal: begin
        // PC already holds PC+4 here, so it is the link value.
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PcSrcJump;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RegDstRa;
        ctrl.mem_to_reg = MemToRegPc;
        state_d         = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset forces every output low immediately, independent of the clock.
  assign ctrl_out      = rst_i ? '0 : ctrl;
  assign alu_control_o = rst_i ? '0 : ALU_CTRL_W'(alu_op);

  assign pc_en_o      = ctrl_out.pc_write | (ctrl_out.pc_write_cond & zero_i);
  assign ir_write_o   = ctrl_out.ir_write;
  assign i_or_d_o     = ctrl_out.i_or_d;
  assign mem_read_o   = ctrl_out.mem_read;
  assign mem_write_o  = ctrl_out.mem_write;
  assign reg_write_o  = ctrl_out.reg_write;
  assign reg_dst_o    = ctrl_out.reg_dst;
  assign mem_to_reg_o = ctrl_out.mem_to_reg;
  assign alu_src_a_o  = ctrl_out.alu_src_a;
  assign alu_src_b_o  = ctrl_out.alu_src_b;
  assign pc_source_o  = ctrl_out.pc_source;
  assign hilo_write_o = ctrl_out.hilo_write;
  assign hilo_sel_o   = ctrl_out.hilo_sel;
  assign md_start_o   = ctrl_out.md_start;
  assign md_busy_o    = ctrl_out.md_busy;
  assign illegal_op_o = ctrl_out.illegal_op;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle expected control vectors are queued when an
// instruction is set up and popped/compared at each negedge.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pc_en;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       hilo_write;
    logic       hilo_sel;
    logic       md_start;
    logic       md_busy;
    logic       illegal_op;
  } vec_t;

  localparam int KZero = 0, KFetch = 1, KDecode = 2, KDecodeIll = 3, KMemAdr = 4, KMemRd = 5;
  localparam int KMemWb = 6, KMemWr = 7, KExec = 8, KExecMd = 9, KExecIll = 10, KAluWb = 11;
  localparam int KAluWbHi = 12, KAluWbLo = 13, KMdWait = 14, KMdWaitLast = 15, KAddiEx = 16;
  localparam int KAddiWb = 17, KBranch = 18, KJump = 19, KJal = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst1 = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic       pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       alu_src_a, hilo_write, hilo_sel, md_start, md_busy, illegal_op;
  logic [2:0] alu_control;

  logic       pc_en1, ir_write1, i_or_d1, mem_read1, mem_write1, reg_write1;
  logic [1:0] reg_dst1, mem_to_reg1, alu_src_b1, pc_source1;
  logic       alu_src_a1, hilo_write1, hilo_sel1, md_start1, md_busy1, illegal_op1;
  logic [2:0] alu_control1;

  vec_t obs, obs1;
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (8),
    .ALU_CTRL_W (3)
  ) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .pc_en_o(pc_en), .ir_write_o(ir_write), .i_or_d_o(i_or_d), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
    .mem_to_reg_o(mem_to_reg), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .alu_control_o(alu_control), .pc_source_o(pc_source), .hilo_write_o(hilo_write),
    .hilo_sel_o(hilo_sel), .md_start_o(md_start), .md_busy_o(md_busy),
    .illegal_op_o(illegal_op)
  );

  multicycle_control_unit #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (1),
    .ALU_CTRL_W (3)
  ) dut1 (
    .clk_i(clk), .rst_i(rst1), .opcode_i(opcode), .funct_i(funct), .zero_i(zero),
    .pc_en_o(pc_en1), .ir_write_o(ir_write1), .i_or_d_o(i_or_d1), .mem_read_o(mem_read1),
    .mem_write_o(mem_write1), .reg_write_o(reg_write1), .reg_dst_o(reg_dst1),
    .mem_to_reg_o(mem_to_reg1), .alu_src_a_o(alu_src_a1), .alu_src_b_o(alu_src_b1),
    .alu_control_o(alu_control1), .pc_source_o(pc_source1), .hilo_write_o(hilo_write1),
    .hilo_sel_o(hilo_sel1), .md_start_o(md_start1), .md_busy_o(md_busy1),
    .illegal_op_o(illegal_op1)
  );

  assign obs = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_control, pc_source, hilo_write, hilo_sel, md_start,
                md_busy, illegal_op};
  assign obs1 = {pc_en1, ir_write1, i_or_d1, mem_read1, mem_write1, reg_write1, reg_dst1,
                 mem_to_reg1, alu_src_a1, alu_src_b1, alu_control1, pc_source1, hilo_write1,
                 hilo_sel1, md_start1, md_busy1, illegal_op1};

  // Expected control vector for one cycle, written directly from the state table.
  function automatic vec_t exp_vec(input int kind, input logic [2:0] alu, input logic z);
    vec_t v;
    v = '0;
    case (kind)
      KFetch: begin
        v.pc_en = 1'b1; v.ir_write = 1'b1; v.mem_read = 1'b1; v.alu_src_b = 2'b01;
      end
      KDecode:    v.alu_src_b = 2'b11;
      KDecodeIll: begin v.alu_src_b = 2'b11; v.illegal_op = 1'b1; end
      KMemAdr, KAddiEx: begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; end
      KMemRd: begin v.mem_read = 1'b1; v.i_or_d = 1'b1; end
      KMemWb: begin v.reg_write = 1'b1; v.mem_to_reg = 2'b01; end
      KMemWr: begin v.mem_write = 1'b1; v.i_or_d = 1'b1; end
      KExec:  begin v.alu_src_a = 1'b1; v.alu_control = alu; end
      KExecMd: begin v.alu_src_a = 1'b1; v.alu_control = alu; v.md_start = 1'b1; end
      KExecIll: begin v.alu_src_a = 1'b1; v.illegal_op = 1'b1; end
      KAluWb: begin v.reg_write = 1'b1; v.reg_dst = 2'b01; end
      KAluWbHi: begin v.reg_write = 1'b1; v.reg_dst = 2'b01; v.mem_to_reg = 2'b11; end
      KAluWbLo: begin
        v.reg_write = 1'b1; v.reg_dst = 2'b01; v.mem_to_reg = 2'b11; v.hilo_sel = 1'b1;
      end
      KMdWait:     v.md_busy = 1'b1;
      KMdWaitLast: begin v.md_busy = 1'b1; v.hilo_write = 1'b1; end
      KAddiWb:     v.reg_write = 1'b1;
      KBranch: begin
        v.alu_src_a = 1'b1; v.alu_control = 3'b001; v.pc_source = 2'b01; v.pc_en = z;
      end
      KJump: begin v.pc_en = 1'b1; v.pc_source = 2'b10; end
      KJal: begin
        v.pc_en = 1'b1; v.pc_source = 2'b10; v.reg_write = 1'b1; v.reg_dst = 2'b10;
        v.mem_to_reg = 2'b10;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic push(input int kind, input logic [2:0] alu = 3'b000, input logic z = 1'b0);
    exp_q.push_back(exp_vec(kind, alu, z));
  endtask

  task automatic check(input vec_t o, input vec_t e, input string tag);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Pop one expectation and compare it against the current outputs.
  task automatic check_now(input string tag, input bit use1);
    vec_t e;
    e = exp_q.pop_front();
    check(use1 ? obs1 : obs, e, tag);
  endtask

  // One cycle per queued expectation: compare at negedge, advance past posedge.
  task automatic drain(input string tag, input bit use1);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check_now($sformatf("%s[%0d]", tag, i), use1);
      i++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fn_tab [6];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};

    // Reset holds every output low; FETCH shows up right after release.
    @(posedge clk);
    #1;
    push(KZero);
    check_now("reset", 1'b0);
    start_instr(6'h23, 6'h00, 1'b0);
    rst = 1'b0;
    push(KFetch); push(KDecode); push(KMemAdr); push(KMemRd); push(KMemWb);
    drain("lw", 1'b0);

    start_instr(6'h2b, 6'h00, 1'b0);
    push(KFetch); push(KDecode); push(KMemAdr); push(KMemWr);
    drain("sw", 1'b0);

    start_instr(6'h04, 6'h00, 1'b1);
    push(KFetch); push(KDecode); push(KBranch, 3'b001, 1'b1);
    drain("beq_taken", 1'b0);

    start_instr(6'h04, 6'h00, 1'b0);
    push(KFetch); push(KDecode); push(KBranch, 3'b001, 1'b0);
    drain("beq_not_taken", 1'b0);

    for (int i = 0; i < 6; i++) begin
      start_instr(6'h00, fn_tab[i], 1'b0);
      push(KFetch); push(KDecode); push(KExec, 3'(i)); push(KAluWb);
      drain($sformatf("rtype%0d", i), 1'b0);
    end

    start_instr(6'h08, 6'h00, 1'b0);
    push(KFetch); push(KDecode); push(KAddiEx); push(KAddiWb);
    drain("addi", 1'b0);

    // mult: 4 MDWAIT cycles, next FETCH on cycle 8.
    start_instr(6'h00, 6'h18, 1'b0);
    push(KFetch); push(KDecode); push(KExecMd, 3'b110);
    push(KMdWait); push(KMdWait); push(KMdWait); push(KMdWaitLast);
    drain("mult", 1'b0);

    start_instr(6'h00, 6'h1a, 1'b0);
    push(KFetch); push(KDecode); push(KExecMd, 3'b111);
    for (int i = 0; i < 7; i++) push(KMdWait);
    push(KMdWaitLast);
    drain("div8", 1'b0);

    start_instr(6'h00, 6'h10, 1'b0);
    push(KFetch); push(KDecode); push(KExec, 3'b000); push(KAluWbHi);
    drain("mfhi", 1'b0);

    start_instr(6'h00, 6'h12, 1'b0);
    push(KFetch); push(KDecode); push(KExec, 3'b000); push(KAluWbLo);
    drain("mflo", 1'b0);

    start_instr(6'h02, 6'h00, 1'b0);
    push(KFetch); push(KDecode); push(KJump);
    drain("j", 1'b0);

    start_instr(6'h03, 6'h00, 1'b0);
    push(KFetch); push(KDecode); push(KJal);
    drain("jal", 1'b0);

    start_instr(6'h3f, 6'h00, 1'b0);
    push(KFetch); push(KDecodeIll);
    drain("ill_opcode", 1'b0);

    start_instr(6'h00, 6'h3f, 1'b0);
    push(KFetch); push(KDecode); push(KExecIll);
    drain("ill_funct", 1'b0);

    // Reset asserted during DECODE, released before the next edge.
    start_instr(6'h23, 6'h00, 1'b0);
    push(KFetch);
    drain("pre_rst_decode", 1'b0);
    #1 rst = 1'b1;
    #1;
    push(KZero);
    check_now("rst_in_decode", 1'b0);
    #1 rst = 1'b0;
    start_instr(6'h08, 6'h00, 1'b0);
    push(KFetch); push(KDecode); push(KAddiEx); push(KAddiWb);
    drain("after_rst_decode", 1'b0);

    // Reset during MDWAIT aborts: no hilo_write at any point afterwards.
    start_instr(6'h00, 6'h18, 1'b0);
    push(KFetch); push(KDecode); push(KExecMd, 3'b110); push(KMdWait); push(KMdWait);
    drain("mult_pre_rst", 1'b0);
    rst = 1'b1;
    #1;
    push(KZero);
    check_now("rst_in_mdwait", 1'b0);
    for (int i = 0; i < 3; i++) push(KZero);
    drain("rst_hold", 1'b0);
    start_instr(6'h02, 6'h00, 1'b0);
    rst = 1'b0;
    push(KFetch); push(KDecode); push(KJump); push(KFetch);
    drain("after_rst_mdwait", 1'b0);

    // div with DIV_CYCLES=1 on the second instance: one MDWAIT cycle.
    rst  = 1'b1;
    start_instr(6'h00, 6'h1a, 1'b0);
    rst1 = 1'b0;
    push(KFetch); push(KDecode); push(KExecMd, 3'b111); push(KMdWaitLast); push(KFetch);
    drain("div1", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle MIPS decoder. It is a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared memory and a single ALU. It adds parametrised multiply/divide latency with an internal busy counter, HI/LO writeback for mfhi/mflo, and jal link to r31. It sits between the instruction register and the multi-cycle datapath muxes.

Parameters:
MULT_CYCLES, 4, cycles the mult unit needs after start (>=1)
DIV_CYCLES, 8, cycles the div unit needs after start (>=1)
ALU_CTRL_W, 3, ALU control width (encoding unchanged from single-cycle: add 000, sub 001, and 010, or 011, nor 100, slt 101, mult 110, div 111)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
pc_en  out  1  pc_write | (pc_write_cond & zero), combinational on zero
ir_write  out  1  latch instruction register
i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
reg_write  out  1  register file write
reg_dst  out  2  00 = rt, 01 = rd, 10 = r31
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC (link), 11 = HI/LO
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
alu_control  out  ALU_CTRL_W  ALU operation
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
hilo_write  out  1  latch mult/div result into HI/LO
hilo_sel  out  1  0 = HI, 1 = LO
md_start  out  1  one-cycle start pulse to the mult/div unit
md_busy  out  1  high while in MDWAIT
illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- Reset: asynchronous. State goes to FETCH and the counter to 0. All outputs are 0 while rst=1. The first rising edge after release performs FETCH.
- Outputs are Moore outputs of the state, except pc_en. Any strobe not listed for a state is 0; alu_control defaults to add.
- FETCH: mem_read, ir_write, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_source=00, pc_write. Next state: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> EXEC
  - addi -> ADDIEX
  - beq -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - other -> FETCH, with illegal_op pulsed.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read, i_or_d=1 -> MEMWB.
- MEMWB: reg_write, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEMWR: mem_write, i_or_d=1 -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - add/sub/and/or/nor/slt -> ALUWB.
  - mult/div: md_start=1, counter loaded with MULT_CYCLES-1 or DIV_CYCLES-1 -> MDWAIT.
  - mfhi/mflo -> ALUWB with HI/LO source.
  - unknown funct -> FETCH, with illegal_op pulsed.
- ALUWB: reg_write, reg_dst=01. mem_to_reg=00, or 11 for mfhi/mflo with hilo_sel=0 (mfhi) or 1 (mflo). Next: FETCH.
- MDWAIT: md_busy=1.
  - If counter==0: hilo_write=1, next FETCH.
  - Else: counter decrements, stay in MDWAIT.
  - So MDWAIT lasts exactly N cycles, and a mult instruction totals 3+MULT_CYCLES cycles.
- ADDIEX: alu_src_a=1, alu_src_b=10, add -> ADDIWB.
- ADDIWB: reg_write, reg_dst=00, mem_to_reg=00 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond, pc_source=01 -> FETCH.
- JUMP: pc_write, pc_source=10 -> FETCH.
- JAL: pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10 -> FETCH. The PC register still holds PC+4 during this cycle.
- Instruction latencies: lw 5, sw 4, R-type/addi/mfhi/mflo 4, beq/j/jal 3, illegal 2.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)). Minimum 1 bit.
- Reset asserted mid-MDWAIT aborts the operation: no hilo_write, md_busy drops at once.
- The opcode/funct inputs are sampled only in DECODE/EXEC; the IR is stable outside FETCH.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - funct constants
  - ALU control codes
  - mem_to_reg, reg_dst, alu_src_b and pc_source codes
  - the state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, MDWAIT, ADDIEX, ADDIWB, BRANCH, JUMP, JAL
- One natural sub-module: md_latency_counter.
  - Inputs: load, load_value, enable.
  - Output: done.
  - It is instantiated once.

Test Plan:
- rst=1 mid-DECODE -> all outputs 0 immediately. After release, the first cycle shows ir_write=1, mem_read=1, pc_en=1.
- lw (opcode 100011) -> 5 cycles. MEMRD has i_or_d=1, mem_read=1. MEMWB has reg_write=1, mem_to_reg=01, reg_dst=00. Then back to FETCH.
- beq with zero=1 vs zero=0 -> BRANCH shows pc_en=1 vs 0, pc_source=01, alu_control=001. 3 cycles each.
- mult (funct 011000), MULT_CYCLES=4:
  - EXEC shows md_start=1 and alu_control=110.
  - md_busy=1 for 4 cycles, with hilo_write=1 on the 4th.
  - Next instruction fetched in cycle 8.
  - Repeat with div at DIV_CYCLES=1: exactly 1 MDWAIT cycle.
- mflo (funct 010010) -> ALUWB with reg_write=1, mem_to_reg=11, hilo_sel=1, reg_dst=01. jal (000011) -> reg_dst=10, mem_to_reg=10, pc_source=10, pc_en=1.
- Opcode 111111 -> illegal_op pulses in DECODE, no reg_write/mem_write, FETCH on the next cycle. rst asserted during MDWAIT -> no hilo_write is ever seen.
